dmem_lsu: RTL

- Load/store initiator that drives the DMem word-wide byte-masked port (MemAddress / MemWriteData / MemWriteMask / MemReadData) from core-side byte, halfword and word requests.
- Sits between the CPU execute stage and DMem.
- Converts byte addresses and sizes into word address plus lane mask, and aligns and extends read data.
- Optionally splits misaligned accesses into two word accesses.

---
 rtl/dmem_lsu_pkg.sv | 33 +++
 rtl/dmem_lane_align.sv | 36 +++
 rtl/dmem_lsu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared encodings, FSM states and lane-mask constants for dmem_lsu
package dmem_lsu_pkg;

   localparam int WORD_BYTES = 4;

   localparam logic [1:0] SZ_B   = 2'd0;
   localparam logic [1:0] SZ_H   = 2'd1;
   localparam logic [1:0] SZ_W   = 2'd2;
   localparam logic [1:0] SZ_ILL = 2'd3;

   localparam logic [3:0] BASE_MASK_B = 4'b0001;
   localparam logic [3:0] BASE_MASK_H = 4'b0011;
   localparam logic [3:0] BASE_MASK_W = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_LO_WAIT,
      ST_HI,
      ST_HI_WAIT,
      ST_DONE
   } state_t;

   function automatic logic [3:0] base_mask(input logic [1:0] size);
      case (size)
         SZ_B:    base_mask = BASE_MASK_B;
         SZ_H:    base_mask = BASE_MASK_H;
         SZ_W:    base_mask = BASE_MASK_W;
         default: base_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane mask/data placement and load-data alignment/extension
module dmem_lane_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_lo_word,
   input  logic [31:0] i_hi_word,
   output logic [7:0]  o_m64,
   output logic [63:0] o_d64,
   output logic        o_split,
   output logic [31:0] o_rdata
);

   logic [4:0]  w_shamt;
   logic [31:0] w_hi;
   logic [31:0] w_r;

   always_comb begin
      w_shamt = {i_off, 3'b000};
      o_m64   = {4'b0000, base_mask(i_size)} << i_off;
      o_d64   = {32'b0, i_wdata} << w_shamt;
      o_split = |o_m64[7:4];
      // the upper word only contributes when the access really crossed into it
      w_hi    = o_split ? i_hi_word : 32'b0;
      w_r     = 32'({w_hi, i_lo_word} >> w_shamt);
      case (i_size)
         SZ_B:    o_rdata = {{24{~i_unsigned & w_r[7]}}, w_r[7:0]};
         SZ_H:    o_rdata = {{16{~i_unsigned & w_r[15]}}, w_r[15:0]};
         default: o_rdata = w_r;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store initiator for the word-wide byte-masked DMem port
// Define DMEM_LSU_SPLIT_EN to split misaligned accesses into LO and HI word accesses.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [31:0]       MemWriteData,
   output logic [3:0]        MemWriteMask,
   input  logic [31:0]       MemReadData
);

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic              r_uns;
   logic [ADDR_W-3:0] r_word;
   logic [31:0]       r_wdata;
   logic [31:0]       r_lo_word;
   logic [31:0]       r_hi_word;

   logic              w_idle;
   logic              w_we;
   logic [1:0]        w_size;
   logic [1:0]        w_off;
   logic              w_uns;
   logic [ADDR_W-3:0] w_word;
   logic [31:0]       w_wdata;
   logic [31:0]       w_lo;
   logic [31:0]       w_hi;
   logic [7:0]        w_m64;
   logic [63:0]       w_d64;
   logic              w_split;
   logic [31:0]       w_rdata;
   logic              w_err;
   logic              w_sel_hi;
   logic [3:0]        w_lane_mask;
   logic [31:0]       w_lane_data;
   logic [ADDR_W-1:0] w_lane_addr;
   logic [ADDR_W-1:0] w_hi_addr;

   assign w_idle    = (r_state == ST_IDLE);
   assign req_ready = w_idle && rst_n;

   // in IDLE the lane math runs on the live request so the first access issues on the accept edge
   assign w_we    = w_idle ? req_we                   : r_we;
   assign w_size  = w_idle ? req_size                 : r_size;
   assign w_off   = w_idle ? req_addr[1:0]            : r_off;
   assign w_uns   = w_idle ? req_unsigned             : r_uns;
   assign w_word  = w_idle ? req_addr[ADDR_W-1:2]     : r_word;
   assign w_wdata = w_idle ? req_wdata                : r_wdata;
   assign w_lo    = (r_state == ST_LO_WAIT) ? MemReadData : r_lo_word;
   assign w_hi    = (r_state == ST_HI_WAIT) ? MemReadData : r_hi_word;

   dmem_lane_align u_align (
      .i_size     (w_size),
      .i_off      (w_off),
      .i_unsigned (w_uns),
      .i_wdata    (w_wdata),
      .i_lo_word  (w_lo),
      .i_hi_word  (w_hi),
      .o_m64      (w_m64),
      .o_d64      (w_d64),
      .o_split    (w_split),
      .o_rdata    (w_rdata)
   );

`ifdef DMEM_LSU_SPLIT_EN
   assign w_err = (w_size == SZ_ILL);
`else
   assign w_err = (w_size == SZ_ILL) || w_split;
`endif

   assign w_hi_addr   = {r_word, 2'b00} + ADDR_W'(WORD_BYTES);
   assign w_sel_hi    = (w_next == ST_HI);
   assign w_lane_mask = w_sel_hi ? w_m64[7:4]  : w_m64[3:0];
   assign w_lane_data = w_sel_hi ? w_d64[63:32] : w_d64[31:0];
   assign w_lane_addr = w_sel_hi ? w_hi_addr   : {w_word, 2'b00};

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (req_valid) w_next = w_err ? ST_DONE : ST_LO;
`ifdef DMEM_LSU_SPLIT_EN
         ST_LO:      w_next = r_we ? (w_split ? ST_HI : ST_DONE) : ST_LO_WAIT;
         ST_LO_WAIT: w_next = w_split ? ST_HI : ST_DONE;
         ST_HI:      w_next = r_we ? ST_DONE : ST_HI_WAIT;
         ST_HI_WAIT: w_next = ST_DONE;
`else
         ST_LO:      w_next = r_we ? ST_DONE : ST_LO_WAIT;
         ST_LO_WAIT: w_next = ST_DONE;
`endif
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_off        <= 2'b00;
         r_uns        <= 1'b0;
         r_word       <= '0;
         r_wdata      <= 32'b0;
         r_lo_word    <= 32'b0;
         r_hi_word    <= 32'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'b0;
         rsp_err      <= 1'b0;
         MemAddress   <= '0;
         MemWriteData <= 32'b0;
         MemWriteMask <= 4'b0000;
      end else begin
         r_state <= w_next;

         if (w_idle && req_valid) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_off     <= req_addr[1:0];
            r_uns     <= req_unsigned;
            r_word    <= req_addr[ADDR_W-1:2];
            r_wdata   <= req_wdata;
            r_hi_word <= 32'b0;
         end
         if (r_state == ST_LO_WAIT) r_lo_word <= MemReadData;
         if (r_state == ST_HI_WAIT) r_hi_word <= MemReadData;

         rsp_valid <= (w_next == ST_DONE);
         rsp_err   <= w_idle && (w_next == ST_DONE);
         rsp_rdata <= ((w_next == ST_DONE) &&
                       (r_state == ST_LO_WAIT || r_state == ST_HI_WAIT)) ? w_rdata : 32'b0;

         // address/data hold between accesses; only the mask is forced back to zero
         MemWriteMask <= 4'b0000;
         if (w_next == ST_LO || w_next == ST_HI) begin
            MemAddress <= w_lane_addr;
            if (w_we) begin
               MemWriteMask <= w_lane_mask;
               MemWriteData <= w_lane_data;
            end
         end
      end
   end

endmodule
